// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters per entry.
// Lookups are combinational from table state; EX updates train the table one cycle later.
package bp_pkg;
  typedef struct packed {
    logic        is_jump;
    logic        taken;
    logic [31:0] target;
  } upd_req_t;
endpackage

module btb_entry
  import bp_pkg::*;
#(
  parameter int TAG_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             sel,
  input  logic [TAG_W-1:0] upd_tag,
  input  upd_req_t         req,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [31:0]      target,
  output logic             is_jump,
  output logic [1:0]       ctr
);
  logic hit;
  assign hit = valid && (tag == upd_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      tag     <= '0;
      target  <= '0;
      is_jump <= 1'b0;
      ctr     <= 2'b00;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (sel) begin
      if (hit) begin
        if (req.taken) begin
          ctr     <= (ctr == 2'b11) ? ctr : ctr + 2'd1;
          target  <= req.target;
          is_jump <= req.is_jump;
        end else begin
          ctr <= (ctr == 2'b00) ? ctr : ctr - 2'd1;
        end
      end else if (req.taken) begin
        // miss-and-taken allocates over whatever alias sat at this index
        valid   <= 1'b1;
        tag     <= upd_tag;
        target  <= req.target;
        is_jump <= req.is_jump;
        ctr     <= 2'b10;
      end
    end
  end
endmodule

module branch_predictor
  import bp_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_jump,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  input  logic        bp_clear,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX;

  logic [BTB_ENTRIES-1:0]            ent_valid, ent_jump;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0] ent_tag;
  logic [BTB_ENTRIES-1:0][31:0]      ent_target;
  logic [BTB_ENTRIES-1:0][1:0]       ent_ctr;

  logic [IDX-1:0]   uidx, lidx;
  logic [TAG_W-1:0] utag, ltag;
  upd_req_t         req;
  logic             hit;
  logic             unused_pc_lsbs;

  assign uidx = upd_pc[IDX+1:2];
  assign utag = upd_pc[31:IDX+2];
  assign lidx = if_pc[IDX+1:2];
  assign ltag = if_pc[31:IDX+2];
  assign req  = '{is_jump: upd_is_jump, taken: upd_taken, target: upd_target};
  assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

  for (genvar g = 0; g < BTB_ENTRIES; g++) begin : g_ent
    btb_entry #(.TAG_W(TAG_W)) u_ent (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (bp_clear),
      .sel     (upd_valid && (uidx == IDX'(g))),
      .upd_tag (utag),
      .req     (req),
      .valid   (ent_valid[g]),
      .tag     (ent_tag[g]),
      .target  (ent_target[g]),
      .is_jump (ent_jump[g]),
      .ctr     (ent_ctr[g])
    );
  end

  // no bypass: a same-cycle update is seen only after the edge
  assign hit        = ent_valid[lidx] && (ent_tag[lidx] == ltag);
  assign pred_valid = hit;
  assign pred_taken = hit && (ent_jump[lidx] || ent_ctr[lidx][1]);
  assign pred_pc    = pred_taken ? ent_target[lidx] : if_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd_valid) begin
      stat_branches <= stat_branches + 32'd1;
      if (upd_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expected lookup/stat values,
// a negedge monitor pops and compares them against the live outputs.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_pc;
  logic        upd_valid, upd_is_jump, upd_taken, upd_mispredict, bp_clear;
  logic [31:0] upd_pc, upd_target;
  logic [31:0] stat_branches, stat_mispredicts;

  typedef struct {
    string       name;
    logic        pv, pt;
    logic [31:0] ppc, sb, sm;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  branch_predictor #(.BTB_ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .bp_clear(bp_clear), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  // monitor: one expectation per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (pred_valid !== e.pv || pred_taken !== e.pt || pred_pc !== e.ppc ||
          stat_branches !== e.sb || stat_mispredicts !== e.sm) begin
        n_bad++;
        $display("FAIL %s: got v=%b t=%b pc=%h br=%0d mp=%0d, want v=%b t=%b pc=%h br=%0d mp=%0d",
                 e.name, pred_valid, pred_taken, pred_pc, stat_branches, stat_mispredicts,
                 e.pv, e.pt, e.ppc, e.sb, e.sm);
      end
    end
  end

  task automatic set_upd(input logic [31:0] pc, input logic j, input logic t,
                         input logic [31:0] tgt, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_is_jump = j; upd_taken = t;
    upd_target = tgt; upd_mispredict = mis;
  endtask

  // one full cycle: lookup pc, queue expectation, let the edge apply any pending update
  task automatic chk(input string name, input logic [31:0] pc, input logic pv, input logic pt,
                     input logic [31:0] ppc, input logic [31:0] sb, input logic [31:0] sm);
    exp_t e;
    if_pc = pc;
    e = '{name: name, pv: pv, pt: pt, ppc: ppc, sb: sb, sm: sm};
    exp_q.push_back(e);
    @(negedge clk); #1;
    @(posedge clk); #1;
    upd_valid = 1'b0; bp_clear = 1'b0; upd_mispredict = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; if_pc = 32'h100; bp_clear = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0; upd_taken = 1'b0;
    upd_target = '0; upd_mispredict = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("reset",       32'h100, 0, 0, 32'h104, 0, 0);
    rst_n = 1'b1;
    chk("post_reset",  32'h100, 0, 0, 32'h104, 0, 0);

    set_upd(32'h100, 0, 1, 32'h80, 1);
    chk("alloc_pre",   32'h100, 0, 0, 32'h104, 0, 0);
    chk("alloc",       32'h100, 1, 1, 32'h80, 1, 1);

    set_upd(32'h100, 0, 0, 32'h0, 0);
    chk("nt1_pre",     32'h100, 1, 1, 32'h80, 1, 1);
    set_upd(32'h100, 0, 0, 32'h0, 0);
    chk("ctr01",       32'h100, 1, 0, 32'h104, 2, 1);
    set_upd(32'h100, 0, 0, 32'h0, 0);
    chk("ctr00",       32'h100, 1, 0, 32'h104, 3, 1);
    set_upd(32'h100, 0, 1, 32'h80, 1);
    chk("ctr00_sat",   32'h100, 1, 0, 32'h104, 4, 1);
    set_upd(32'h100, 0, 1, 32'h80, 0);
    chk("ctr01_up",    32'h100, 1, 0, 32'h104, 5, 2);
    chk("ctr10",       32'h100, 1, 1, 32'h80, 6, 2);

    set_upd(32'h140, 0, 1, 32'h200, 1);
    chk("alias_pre",   32'h100, 1, 1, 32'h80, 6, 2);
    chk("alias_miss",  32'h100, 0, 0, 32'h104, 7, 3);
    chk("alias_hit",   32'h140, 1, 1, 32'h200, 7, 3);
    set_upd(32'h300, 0, 0, 32'h0, 0);
    chk("ntmiss_pre",  32'h300, 0, 0, 32'h304, 7, 3);
    chk("ntmiss",      32'h300, 0, 0, 32'h304, 8, 3);
    chk("ntmiss_keep", 32'h140, 1, 1, 32'h200, 8, 3);

    set_upd(32'h10, 1, 1, 32'h3FC, 1);
    chk("jump_pre",    32'h10, 0, 0, 32'h14, 8, 3);
    set_upd(32'h10, 1, 1, 32'h500, 0);
    chk("bypass",      32'h10, 1, 1, 32'h3FC, 9, 4);
    chk("post_bypass", 32'h10, 1, 1, 32'h500, 10, 4);
    chk("pc_wrap",     32'hFFFF_FFFC, 0, 0, 32'h0, 10, 4);

    set_upd(32'h20, 0, 1, 32'h40, 1);
    bp_clear = 1'b1;
    chk("clr_pre",     32'h140, 1, 1, 32'h200, 10, 4);
    chk("clr_140",     32'h140, 0, 0, 32'h144, 11, 5);
    chk("clr_20",      32'h20, 0, 0, 32'h24, 11, 5);
    chk("clr_10",      32'h10, 0, 0, 32'h14, 11, 5);

    set_upd(32'h10, 1, 1, 32'h500, 0);
    chk("realloc_pre", 32'h10, 0, 0, 32'h14, 11, 5);
    chk("realloc",     32'h10, 1, 1, 32'h500, 12, 5);

    // async reset dropped between edges, with an update pending that must be discarded
    begin
      exp_t e;
      set_upd(32'h10, 1, 1, 32'h600, 1);
      if_pc = 32'h10;
      #2 rst_n = 1'b0;
      e = '{name: "async_rst", pv: 0, pt: 0, ppc: 32'h14, sb: 0, sm: 0};
      exp_q.push_back(e);
      @(negedge clk); #1;
      @(posedge clk); #1;
      upd_valid = 1'b0; upd_mispredict = 1'b0;
      rst_n = 1'b1;
    end
    chk("after_rst",   32'h10, 0, 0, 32'h14, 0, 0);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!stim_done && budget < 2000) begin @(posedge clk); budget++; end
    repeat (2) @(posedge clk);
    if (!stim_done || exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: stimulus done=%0d pending=%0d, want done=1 pending=0",
               stim_done, exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters.

- **Where it sits:** between IF and EX.
- **IF side:** IF presents the fetch PC and receives `pred_valid` / `pred_pc`. These travel down the pipeline as `prediction_valid` / `predicted_pc`.
- **EX side:** the execute stage returns the resolved outcome of every valid branch/jump. The predictor trains on it and keeps resolution statistics.

## Interface

Parameters:
- `BTB_ENTRIES`, default 16: number of entries. Power of two, ≥2. `IDX = log2(BTB_ENTRIES)`.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `if_pc`, input, 32: fetch PC to predict.
- `pred_valid`, output, 1: BTB hit for `if_pc`.
- `pred_taken`, output, 1: predicted taken, qualified by hit.
- `pred_pc`, output, 32: predicted next PC.
- `upd_valid`, input, 1: a valid branch/jump resolved in EX this cycle.
- `upd_pc`, input, 32: PC of the resolved instruction.
- `upd_is_jump`, input, 1: the instruction was JAL/JALR.
- `upd_taken`, input, 1: actual outcome; always 1 for jumps.
- `upd_target`, input, 32: actual target, bit 0 already cleared.
- `upd_mispredict`, input, 1: EX flagged a mispredict for this instruction.
- `bp_clear`, input, 1: synchronous invalidate of all entries.
- `stat_branches`, output, 32: count of `upd_valid` cycles.
- `stat_mispredicts`, output, 32: count of `upd_valid && upd_mispredict` cycles.

## Operation

Entry format and addressing:
- Each entry holds `valid`, `tag[31-IDX-2:0]`, `target[31:0]`, `is_jump`, `ctr[1:0]`.
- Index is `pc[IDX+1:2]`. Tag is `pc[31:IDX+2]`. `pc[1:0]` is ignored.

Lookup (combinational from table state):
- `hit = valid[idx(if_pc)] && tag == tag(if_pc)`.
- `pred_valid = hit`.
- `pred_taken = hit && (is_jump || ctr[1])`.
- `pred_pc = pred_taken ? target : if_pc + 4` (modulo 2^32, so 0xFFFFFFFC wraps to 0x0).

Update (registered, on the edge where `upd_valid=1`), with `uidx = idx(upd_pc)`:
- **Hit at `upd_pc`:**
  - `ctr` saturating increment if `upd_taken`, decrement otherwise (00 floor, 11 ceiling).
  - If `upd_taken`: `target <= upd_target`, `is_jump <= upd_is_jump`.
- **Miss and `upd_taken`:**
  - Allocate: `valid=1`, tag, `target=upd_target`, `is_jump=upd_is_jump`, `ctr=2'b10` (weakly taken).
  - Replaces any aliasing entry at `uidx`.
- **Miss and not taken:** table unchanged.

Statistics:
- `stat_branches += 1` on every `upd_valid` cycle.
- `stat_mispredicts += 1` when `upd_valid && upd_mispredict`.
- Both are 32-bit wrapping (0xFFFFFFFF → 0). Statistics update regardless of `bp_clear`.

`bp_clear`:
- Clears every `valid` bit at the edge.
- Takes priority over a same-cycle update: the table is empty afterwards.
- `tag`, `target` and `ctr` need not be cleared.

Reset (`rst_n=0`, asynchronous):
- All `valid`, `is_jump` and `ctr` cleared; stats = 0.
- Outputs during reset: `pred_valid=0`, `pred_taken=0`, `pred_pc=if_pc+4`, `stat_*=0`.
- Reset asserted mid-update discards that update.

## Timing

- Lookup latency: 0 cycles, `if_pc` to `pred_*` combinational.
- Update latency: 1 cycle. The update sampled at edge N is visible to lookups from the cycle after edge N.
- Lookup and update to the same index in the same cycle: the lookup returns pre-update contents (no bypass).
- Back-to-back updates to the same entry every cycle are applied in order, one step per edge.
- Stats outputs are registered and change only at edges or reset.
- No handshake: `upd_valid` is a one-cycle strobe per resolved instruction. The block never stalls.

## Test plan

All scenarios use `BTB_ENTRIES=16` (`idx = pc[5:2]`, `tag = pc[31:6]`).

1. **Reset:** assert `rst_n=0`, then release; `if_pc=0x100` → `pred_valid=0`, `pred_pc=0x104`, `stat_branches=0`, `stat_mispredicts=0`.
2. **Allocate:** update `pc=0x100`, branch, taken, `target=0x80`, mispredict=1 → next cycle lookup 0x100 gives `pred_valid=1`, `pred_taken=1`, `pred_pc=0x80`; `stat_branches=1`, `stat_mispredicts=1`.
3. **Counter walk:**
   - Starting from scenario 2 (ctr=10), apply not-taken on 0x100 → ctr=01: `pred_pc=0x104` with `pred_valid=1`.
   - Not-taken again → ctr=00.
   - Not-taken a third time → stays 00.
   - Taken → 01, still `pred_pc=0x104`.
   - Taken → 10, `pred_pc=0x80`.
4. **Alias and not-taken miss:**
   - After scenario 2, taken update `pc=0x140`, `target=0x200` → lookup 0x100 misses; lookup 0x140 gives `pred_pc=0x200`.
   - Not-taken update at `pc=0x300` (miss) → lookup 0x300 still misses.
5. **Jump entry and same-cycle bypass:**
   - Jump update `pc=0x10`, `target=0x3FC` → lookup 0x10 gives `pred_taken=1`.
   - In the same cycle as a new update (`pc=0x10`, `target=0x500`), lookup 0x10 still returns 0x3FC; the next cycle returns 0x500.
6. **Clear and async reset:**
   - `bp_clear=1` together with a taken update at `pc=0x20` → all lookups miss afterwards; `stat_branches` still increments.
   - Drop `rst_n` between edges → `pred_valid` and `stat_*` go to 0 immediately, without waiting for a clock edge.
